// File: rtl/img_proc_pkg.sv
// Shared types and constants for the image-processing front-end blocks.
package img_proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned       CNT_W      = 11;
  localparam logic [CNT_W-1:0] WIN_BORDER = 11'd2;
  localparam logic [CNT_W-1:0] CNT_MAX    = 11'd2047;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a level input and flags its rising and falling transitions
// in the cycle the new level is presented.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/matrix_window_ctrl.sv
// Tracks pixel/line position through a frame and flags 3x3 window centres
// whose neighbourhood is complete, aligned to the matrix generator output.
//
// state   | meaning
// IDLE    | after reset, waiting for the first frame sync
// LINE    | counting accepted pixels of the current line
// GAP     | between lines, waiting for line valid to rise
// DONE    | all lines seen, line valid ignored until next frame sync
module matrix_window_ctrl
  import img_proc_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_H = 11'd1280,
  parameter logic [CNT_W-1:0] IMG_V = 11'd720
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_vs,
  input  logic             pre_hs,
  input  logic             pre_clken,
  output logic             win_valid,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             frame_start,
  output logic             frame_done,
  output logic             line_err,
  output logic             err_sticky,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] px_q, px_d, ln_q, ln_d, ln_inc, px_cur;
  logic             err_q, err_d, fs_q, fs_d, fd_q, fd_d, le_q, le_d;
  logic             vs_rise, vs_fall_unused, hs_rise, hs_fall;
  logic             accept, win0;
  logic [1:0]       win_sr_q;
  logic [CNT_W-1:0] col_sr_q, row_sr_q, col_q, row_q;

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (pre_vs),
    .rise_o (vs_rise),
    .fall_o (vs_fall_unused)
  );

  sync_edge_det u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (pre_hs),
    .rise_o (hs_rise),
    .fall_o (hs_fall)
  );

  assign ln_inc = ln_q + 11'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame sync wins from every state, so a short frame restarts cleanly.
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = ST_GAP;
    end else begin
      case (state_q)
        ST_GAP:  if (hs_rise) state_d = ST_LINE;
        ST_LINE: if (hs_fall) state_d = (ln_inc == IMG_V) ? ST_DONE : ST_GAP;
        default: ;
      endcase
    end
  end

  // The first pixel may share its cycle with the line-valid rise, so GAP accepts too.
  always_comb begin
    px_d   = px_q;
    ln_d   = ln_q;
    err_d  = err_q;
    fs_d   = 1'b0;
    fd_d   = 1'b0;
    le_d   = 1'b0;
    accept = 1'b0;
    px_cur = px_q;
    if (vs_rise) begin
      px_d  = '0;
      ln_d  = '0;
      fs_d  = 1'b1;
      err_d = (state_q == ST_LINE) || (state_q == ST_GAP);
    end else begin
      case (state_q)
        ST_GAP: begin
          if (hs_rise) begin
            px_cur = '0;
            accept = pre_clken;
            px_d   = pre_clken ? 11'd1 : 11'd0;
          end
        end
        ST_LINE: begin
          if (hs_fall) begin
            ln_d = ln_inc;
            px_d = '0;
            if (px_q != IMG_H) begin
              le_d  = 1'b1;
              err_d = 1'b1;
            end
            fd_d = (ln_inc == IMG_V);
          end else if (pre_hs && pre_clken) begin
            accept = 1'b1;
            px_d   = sat_inc(px_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign win0 = accept && (px_cur >= WIN_BORDER) && (ln_q >= WIN_BORDER) && (ln_q < IMG_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q     <= '0;
      ln_q     <= '0;
      err_q    <= 1'b0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
      le_q     <= 1'b0;
      win_sr_q <= '0;
      col_sr_q <= '0;
      row_sr_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      px_q     <= px_d;
      ln_q     <= ln_d;
      err_q    <= err_d;
      fs_q     <= fs_d;
      fd_q     <= fd_d;
      le_q     <= le_d;
      win_sr_q <= {win_sr_q[0], win0};
      if (win0) begin
        col_sr_q <= px_cur - 11'd1;
        row_sr_q <= ln_q - 11'd1;
      end
      if (win_sr_q[0]) begin
        col_q <= col_sr_q;
        row_q <= row_sr_q;
      end
    end
  end

  assign win_valid   = win_sr_q[1];
  assign col_cnt     = col_q;
  assign row_cnt     = row_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign line_err    = le_q;
  assign err_sticky  = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Directed bench for matrix_window_ctrl with an 8x4 image: normal, gated,
// short-line, aborted-frame, post-DONE and mid-frame reset scenarios.
module tb_matrix_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pre_vs = 1'b0;
  logic        pre_hs = 1'b0;
  logic        pre_clken = 1'b0;
  logic        win_valid;
  logic [10:0] col_cnt;
  logic [10:0] row_cnt;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic        err_sticky;
  logic [1:0]  state;

  matrix_window_ctrl #(
    .IMG_H (11'd8),
    .IMG_V (11'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_vs      (pre_vs),
    .pre_hs      (pre_hs),
    .pre_clken   (pre_clken),
    .win_valid   (win_valid),
    .col_cnt     (col_cnt),
    .row_cnt     (row_cnt),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .err_sticky  (err_sticky),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Event monitor, sampled on the falling edge.
  int         wv_cnt = 0, fs_cnt = 0, fd_cnt = 0, le_cnt = 0, misalign = 0;
  int         first_col = -1, first_row = -1, last_col = -1, last_row = -1;
  logic       armed = 1'b0;
  logic [1:0] hist = 2'b00;
  int         b_wv, b_fs, b_fd, b_le, b_mis;

  always @(negedge clk) begin
    hist <= {hist[0], pre_hs & pre_clken};
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (line_err)   le_cnt <= le_cnt + 1;
    if (win_valid) begin
      wv_cnt <= wv_cnt + 1;
      if (!hist[1]) misalign <= misalign + 1;
      if (armed) begin
        first_col <= int'(col_cnt);
        first_row <= int'(row_cnt);
        armed     <= 1'b0;
      end
      last_col <= int'(col_cnt);
      last_row <= int'(row_cnt);
    end
    if (frame_start) begin
      fs_cnt <= fs_cnt + 1;
      armed  <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vs_pulse();
    pre_vs = 1'b1;
    tick();
    pre_vs = 1'b0;
    tick(3);
  endtask

  task automatic hs_line(input int n, input bit gated);
    int k = 0;
    pre_hs = 1'b1;
    while (k < n) begin
      pre_clken = 1'b1;
      tick();
      k++;
      if (gated) begin
        pre_clken = 1'b0;
        tick();
      end
    end
    pre_clken = 1'b0;
    pre_hs    = 1'b0;
    tick(4);
  endtask

  task automatic snap();
    b_wv  = wv_cnt;
    b_fs  = fs_cnt;
    b_fd  = fd_cnt;
    b_le  = le_cnt;
    b_mis = misalign;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    check_val("rst_state", state, 0);
    check_val("rst_win_valid", win_valid, 0);
    check_val("rst_err_sticky", err_sticky, 0);
    check_val("rst_frame_start", frame_start, 0);
    rst_n = 1'b1;
    tick(3);
    check_val("idle_after_rst", state, 0);

    // Normal continuous frame
    snap();
    vs_pulse();
    check_val("t1_frame_start", fs_cnt - b_fs, 1);
    check_val("t1_state_gap", state, 2);
    repeat (3) hs_line(8, 1'b0);
    check_val("t1_fd_before_l4", fd_cnt - b_fd, 0);
    check_val("t1_wv_after_l3", wv_cnt - b_wv, 6);
    check_val("t1_state_l3", state, 2);
    hs_line(8, 1'b0);
    check_val("t1_wv_total", wv_cnt - b_wv, 12);
    check_val("t1_frame_done", fd_cnt - b_fd, 1);
    check_val("t1_line_err", le_cnt - b_le, 0);
    check_val("t1_first_col", first_col, 1);
    check_val("t1_first_row", first_row, 1);
    check_val("t1_last_col", last_col, 6);
    check_val("t1_last_row", last_row, 2);
    check_val("t1_state_done", state, 3);
    check_val("t1_err_sticky", err_sticky, 0);
    check_val("t1_align", misalign - b_mis, 0);

    // Line valid after DONE is ignored
    snap();
    hs_line(8, 1'b0);
    hs_line(8, 1'b0);
    check_val("t2_wv", wv_cnt - b_wv, 0);
    check_val("t2_line_err", le_cnt - b_le, 0);
    check_val("t2_frame_done", fd_cnt - b_fd, 0);
    check_val("t2_state", state, 3);

    // Gated strobes
    snap();
    vs_pulse();
    repeat (4) hs_line(8, 1'b1);
    check_val("t3_wv_total", wv_cnt - b_wv, 12);
    check_val("t3_align", misalign - b_mis, 0);
    check_val("t3_frame_done", fd_cnt - b_fd, 1);
    check_val("t3_first_col", first_col, 1);
    check_val("t3_first_row", first_row, 1);
    check_val("t3_last_col", last_col, 6);

    // Short line
    snap();
    vs_pulse();
    hs_line(8, 1'b0);
    hs_line(7, 1'b0);
    check_val("t4_line_err", le_cnt - b_le, 1);
    check_val("t4_err_set", err_sticky, 1);
    hs_line(8, 1'b0);
    hs_line(8, 1'b0);
    check_val("t4_line_err_once", le_cnt - b_le, 1);
    check_val("t4_err_held", err_sticky, 1);
    check_val("t4_frame_done", fd_cnt - b_fd, 1);
    check_val("t4_wv_total", wv_cnt - b_wv, 12);
    vs_pulse();
    check_val("t4_err_cleared", err_sticky, 0);
    check_val("t4_frame_start", fs_cnt - b_fs, 2);

    // Frame sync during the second line
    snap();
    hs_line(8, 1'b0);
    pre_hs = 1'b1;
    pre_clken = 1'b1;
    tick(3);
    pre_clken = 1'b0;
    pre_vs = 1'b1;
    tick();
    pre_vs = 1'b0;
    pre_hs = 1'b0;
    tick(3);
    check_val("t5_frame_start", fs_cnt - b_fs, 1);
    check_val("t5_no_frame_done", fd_cnt - b_fd, 0);
    check_val("t5_err_sticky", err_sticky, 1);
    check_val("t5_state_gap", state, 2);
    check_val("t5_line_err", le_cnt - b_le, 0);
    snap();
    repeat (4) hs_line(8, 1'b0);
    check_val("t5_wv_restart", wv_cnt - b_wv, 12);
    check_val("t5_first_col", first_col, 1);
    check_val("t5_first_row", first_row, 1);
    check_val("t5_frame_done", fd_cnt - b_fd, 1);
    check_val("t5_err_held", err_sticky, 1);

    // Reset mid-line, released mid-frame
    vs_pulse();
    hs_line(8, 1'b0);
    pre_hs = 1'b1;
    pre_clken = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check_val("t6_state", state, 0);
    check_val("t6_win_valid", win_valid, 0);
    check_val("t6_col_cnt", col_cnt, 0);
    check_val("t6_row_cnt", row_cnt, 0);
    check_val("t6_frame_start", frame_start, 0);
    check_val("t6_frame_done", frame_done, 0);
    check_val("t6_line_err", line_err, 0);
    check_val("t6_err_sticky", err_sticky, 0);
    tick();
    rst_n = 1'b1;
    snap();
    tick(4);
    pre_clken = 1'b0;
    pre_hs = 1'b0;
    tick(4);
    hs_line(8, 1'b0);
    hs_line(8, 1'b0);
    check_val("t6_no_wv", wv_cnt - b_wv, 0);
    check_val("t6_still_idle", state, 0);
    check_val("t6_no_line_err", le_cnt - b_le, 0);
    check_val("t6_no_frame_done", fd_cnt - b_fd, 0);
    snap();
    vs_pulse();
    repeat (4) hs_line(8, 1'b0);
    check_val("t6_wv_after_vs", wv_cnt - b_wv, 12);
    check_val("t6_fd_after_vs", fd_cnt - b_fd, 1);
    check_val("t6_first_col", first_col, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
